m_axis_cq_dispatch: RTL and testbench



---
 rtl/m_axis_cq_dispatch.sv | 158 +++++++++++++++
 tb/tb_m_axis_cq_dispatch.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_axis_cq_dispatch.sv
// CQ TLP dispatcher: routes each completer-request packet to a per-BAR consumer port with
// per-port outstanding-read limits. Define CQ_DISPATCH_DROP_EN to drop unmapped-BAR packets.
module m_axis_cq_dispatch #(
    parameter int unsigned DATA_WIDTH      = 128,
    parameter int unsigned KEEP_WIDTH      = DATA_WIDTH / 8,
    parameter int unsigned NUM_PORTS       = 2,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                   user_clk,
    input  logic                   user_reset_n,
    input  logic [DATA_WIDTH-1:0]  s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]  s_axis_tkeep,
    input  logic                   s_axis_tlast,
    input  logic [84:0]            s_axis_tuser,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    output logic [DATA_WIDTH-1:0]  m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]  m_axis_tkeep,
    output logic                   m_axis_tlast,
    output logic [84:0]            m_axis_tuser,
    output logic [NUM_PORTS-1:0]   m_axis_tvalid,
    input  logic [NUM_PORTS-1:0]   m_axis_tready,
    input  logic [NUM_PORTS-1:0]   rd_done,
    output logic [4*NUM_PORTS-1:0] rd_outstanding
`ifdef CQ_DISPATCH_DROP_EN
    ,
    output logic [15:0]            drop_count
`endif
);
    localparam int unsigned PortW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {StIdle, StRoute, StDrop} state_e;

    state_e               state_q, state_d;
    logic [PortW-1:0]     port_q, port_d;
    logic [3:0]           cnt_q [NUM_PORTS];
    logic [3:0]           cnt_d [NUM_PORTS];
    logic [NUM_PORTS-1:0] rd_inc;

    logic [2:0]       hdr_bar;
    logic             hdr_read;
    logic             hdr_mapped;
    logic             hdr_stall;
    logic [PortW-1:0] hdr_port;
    logic [PortW-1:0] sel_port;
    logic             route_en;
    logic             consume;
    logic             handshake;

    assign m_axis_tdata = s_axis_tdata;
    assign m_axis_tkeep = s_axis_tkeep;
    assign m_axis_tlast = s_axis_tlast;
    assign m_axis_tuser = s_axis_tuser;

    always_comb begin
        hdr_bar    = s_axis_tuser[8:6];
        hdr_read   = (s_axis_tuser[5:2] == 4'b0000);
        hdr_mapped = (32'(hdr_bar) < NUM_PORTS);
        hdr_port   = hdr_mapped ? hdr_bar[PortW-1:0] : '0;
        // Stall decision uses only the registered count, never this cycle's rd_done.
        hdr_stall  = hdr_read && (cnt_q[hdr_port] == 4'(MAX_OUTSTANDING));
    end

    always_comb begin
        state_d       = state_q;
        port_d        = port_q;
        sel_port      = port_q;
        route_en      = 1'b0;
        consume       = 1'b0;
        rd_inc        = '0;
        m_axis_tvalid = '0;
        s_axis_tready = 1'b0;

        unique case (state_q)
            StIdle: begin
                sel_port = hdr_port;
`ifdef CQ_DISPATCH_DROP_EN
                consume  = !hdr_mapped;
                route_en = hdr_mapped && !hdr_stall;
`else
                route_en = !hdr_stall;
`endif
            end
            StRoute: route_en = 1'b1;
            StDrop:  consume  = 1'b1;
            default: ;
        endcase

        // Outputs are forced quiet while reset is held, independent of the clock.
        if (user_reset_n) begin
            if (route_en) begin
                m_axis_tvalid[sel_port] = s_axis_tvalid;
                s_axis_tready           = m_axis_tready[sel_port];
            end else if (consume) begin
                s_axis_tready = 1'b1;
            end
        end

        handshake = s_axis_tvalid && s_axis_tready;

        if (handshake) begin
            unique case (state_q)
                StIdle: begin
                    if (consume) begin
                        if (!s_axis_tlast) state_d = StDrop;
                    end else begin
                        port_d = hdr_port;
                        if (hdr_read) rd_inc[hdr_port] = 1'b1;
                        if (!s_axis_tlast) state_d = StRoute;
                    end
                end
                StRoute, StDrop: begin
                    if (s_axis_tlast) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            cnt_d[p] = cnt_q[p];
            if (rd_inc[p] && !rd_done[p]) begin
                cnt_d[p] = cnt_q[p] + 4'd1;
            end else if (!rd_inc[p] && rd_done[p] && (cnt_q[p] != 4'd0)) begin
                cnt_d[p] = cnt_q[p] - 4'd1;
            end
            rd_outstanding[4*p +: 4] = cnt_q[p];
        end
    end

    always_ff @(posedge user_clk or negedge user_reset_n) begin
        if (!user_reset_n) begin
            state_q <= StIdle;
            port_q  <= '0;
            for (int p = 0; p < NUM_PORTS; p++) cnt_q[p] <= 4'd0;
        end else begin
            state_q <= state_d;
            port_q  <= port_d;
            for (int p = 0; p < NUM_PORTS; p++) cnt_q[p] <= cnt_d[p];
        end
    end

`ifdef CQ_DISPATCH_DROP_EN
    logic [15:0] drop_q;

    always_ff @(posedge user_clk or negedge user_reset_n) begin
        if (!user_reset_n) begin
            drop_q <= 16'd0;
        end else if ((state_q == StIdle) && consume && handshake && (drop_q != 16'hffff)) begin
            drop_q <= drop_q + 16'd1;
        end
    end

    assign drop_count = drop_q;
`endif

endmodule

// File: tb/tb_m_axis_cq_dispatch.sv
// Self-checking bench for m_axis_cq_dispatch: directed vector table, reset corner case and
// randomized traffic against a packet-level reference model. Honours CQ_DISPATCH_DROP_EN.
`timescale 1ns/1ps
module tb_m_axis_cq_dispatch;
    localparam int DW   = 128;
    localparam int KW   = DW / 8;
    localparam int NP   = 2;
    localparam int MAXO = 4;
`ifdef CQ_DISPATCH_DROP_EN
    localparam bit DropEn = 1'b1;
`else
    localparam bit DropEn = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [DW-1:0]   s_tdata = '0;
    logic [KW-1:0]   s_tkeep = '0;
    logic            s_tlast = 1'b0;
    logic [84:0]     s_tuser = '0;
    logic            s_tvalid = 1'b0;
    logic            s_tready;
    logic [DW-1:0]   m_tdata;
    logic [KW-1:0]   m_tkeep;
    logic            m_tlast;
    logic [84:0]     m_tuser;
    logic [NP-1:0]   m_tvalid;
    logic [NP-1:0]   m_tready = '0;
    logic [NP-1:0]   rd_done = '0;
    logic [4*NP-1:0] rd_out;
`ifdef CQ_DISPATCH_DROP_EN
    logic [15:0]     drop_count;
`endif

    m_axis_cq_dispatch #(
        .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .NUM_PORTS(NP), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .user_clk(clk), .user_reset_n(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
        .s_axis_tuser(s_tuser), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast),
        .m_axis_tuser(m_tuser), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .rd_done(rd_done), .rd_outstanding(rd_out)
`ifdef CQ_DISPATCH_DROP_EN
        , .drop_count(drop_count)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic          v;
        logic [2:0]    bar;
        logic          rd;
        logic          last;
        logic [NP-1:0] mrdy;
        logic [NP-1:0] done;
        logic [NP-1:0] etv;
        logic          etr;
        int            ec0;
        int            ec1;
    } vec_t;

    vec_t vecs[$];
    int   beats[NP];

    // Reference model state (packet level)
    int            m_cnt[NP];
    bit            m_in_pkt, m_in_drop;
    int            m_cur, m_drops, m_port;
    bit            m_mapped, m_rd, m_hs;
    logic [2:0]    m_bar;
    logic [NP-1:0] e_tv;
    logic          e_tr;
    logic [4*NP-1:0] e_ro;
    bit            m_inc[NP];

    function automatic vec_t mkv(logic v, logic [2:0] bar, logic rd, logic last,
                                 logic [NP-1:0] mrdy, logic [NP-1:0] done,
                                 logic [NP-1:0] etv, logic etr, int ec0, int ec1);
        vec_t r;
        r.v = v; r.bar = bar; r.rd = rd; r.last = last; r.mrdy = mrdy; r.done = done;
        r.etv = etv; r.etr = etr; r.ec0 = ec0; r.ec1 = ec1;
        return r;
    endfunction

    function automatic logic [84:0] mk_user(logic [2:0] bar, logic rd);
        logic [84:0] u;
        u      = {$urandom, $urandom, $urandom};
        u[9]   = 1'b0;
        u[8:6] = bar;
        u[5:2] = rd ? 4'b0000 : 4'b0001;
        return u;
    endfunction

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(logic v, logic [2:0] bar, logic rd, logic last,
                         logic [NP-1:0] mrdy, logic [NP-1:0] done);
        s_tvalid = v;
        s_tuser  = mk_user(bar, rd);
        s_tlast  = last;
        s_tdata  = {$urandom, $urandom, $urandom, $urandom};
        s_tkeep  = KW'($urandom);
        m_tready = mrdy;
        rd_done  = done;
    endtask

    initial begin
        // Directed table; counts are the values visible during that cycle.
        vecs.push_back(mkv(0, 0, 1, 1, 2'b11, 2'b00, 2'b00, 1, 0, 0));
        vecs.push_back(mkv(1, 1, 0, 0, 2'b11, 2'b00, 2'b10, 1, 0, 0));
        vecs.push_back(mkv(1, 1, 0, 0, 2'b11, 2'b00, 2'b10, 1, 0, 0));
        vecs.push_back(mkv(1, 1, 0, 1, 2'b11, 2'b00, 2'b10, 1, 0, 0));
        for (int k = 0; k < 4; k++) vecs.push_back(mkv(1, 0, 1, 1, 2'b11, 2'b00, 2'b01, 1, k, 0));
        vecs.push_back(mkv(1, 0, 1, 1, 2'b11, 2'b00, 2'b00, 0, 4, 0));
        vecs.push_back(mkv(1, 0, 0, 1, 2'b11, 2'b00, 2'b01, 1, 4, 0));
        vecs.push_back(mkv(1, 1, 1, 1, 2'b11, 2'b00, 2'b10, 1, 4, 0));
        vecs.push_back(mkv(1, 0, 1, 1, 2'b11, 2'b01, 2'b00, 0, 4, 1));
        vecs.push_back(mkv(1, 0, 1, 1, 2'b11, 2'b00, 2'b01, 1, 3, 1));
        vecs.push_back(mkv(0, 1, 0, 1, 2'b11, 2'b01, 2'b00, 1, 4, 1));
        vecs.push_back(mkv(0, 1, 0, 1, 2'b11, 2'b01, 2'b00, 1, 3, 1));
        vecs.push_back(mkv(1, 0, 1, 1, 2'b11, 2'b01, 2'b01, 1, 2, 1));
        vecs.push_back(mkv(0, 1, 0, 1, 2'b11, 2'b10, 2'b00, 1, 2, 1));
        vecs.push_back(mkv(0, 1, 0, 1, 2'b11, 2'b10, 2'b00, 1, 2, 0));
        vecs.push_back(mkv(0, 1, 0, 1, 2'b11, 2'b00, 2'b00, 1, 2, 0));
        vecs.push_back(mkv(1, 1, 0, 0, 2'b11, 2'b00, 2'b10, 1, 2, 0));
        for (int k = 0; k < 3; k++) vecs.push_back(mkv(1, 1, 0, 0, 2'b01, 2'b00, 2'b10, 0, 2, 0));
        vecs.push_back(mkv(1, 1, 0, 0, 2'b11, 2'b00, 2'b10, 1, 2, 0));
        vecs.push_back(mkv(1, 1, 0, 1, 2'b11, 2'b00, 2'b10, 1, 2, 0));
        vecs.push_back(mkv(1, 5, 1, 0, 2'b11, 2'b00, DropEn ? 2'b00 : 2'b01, 1, 2, 0));
        vecs.push_back(mkv(1, 5, 1, 1, 2'b11, 2'b00, DropEn ? 2'b00 : 2'b01, 1, DropEn ? 2 : 3, 0));
        vecs.push_back(mkv(0, 1, 0, 1, 2'b11, 2'b00, 2'b00, 1, DropEn ? 2 : 3, 0));
        for (int p = 0; p < NP; p++) beats[p] = 0;

        // Outputs must be quiet while reset is held even with traffic presented.
        #1 drive(1, 0, 0, 1, 2'b11, 2'b00);
        #2;
        chk("reset tvalid", 128'(m_tvalid), 128'(0));
        chk("reset tready", 128'(s_tready), 128'(0));
        chk("reset rd_outstanding", 128'(rd_out), 128'(0));
        #9 rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk); #1;
            drive(vecs[i].v, vecs[i].bar, vecs[i].rd, vecs[i].last, vecs[i].mrdy, vecs[i].done);
            #4;
            chk($sformatf("row%0d tvalid", i), 128'(m_tvalid), 128'(vecs[i].etv));
            chk($sformatf("row%0d tready", i), 128'(s_tready), 128'(vecs[i].etr));
            chk($sformatf("row%0d cnt0", i), 128'(rd_out[3:0]), 128'(vecs[i].ec0));
            chk($sformatf("row%0d cnt1", i), 128'(rd_out[7:4]), 128'(vecs[i].ec1));
            chk($sformatf("row%0d tdata", i), 128'(m_tdata), 128'(s_tdata));
            for (int p = 0; p < NP; p++) if (m_tvalid[p] && m_tready[p]) beats[p]++;
        end
        chk("beats port0", 128'(beats[0]), 128'(DropEn ? 7 : 9));
        chk("beats port1", 128'(beats[1]), 128'(7));
`ifdef CQ_DISPATCH_DROP_EN
        chk("drop_count after BAR5", 128'(drop_count), 128'(1));
`endif

        // Reset asserted mid-packet abandons the packet.
        @(posedge clk); #1;
        drive(1, 1, 0, 0, 2'b11, 2'b00);
        @(posedge clk); #1;
        drive(1, 0, 0, 0, 2'b11, 2'b00);
        #2;
        chk("mid-packet route tvalid", 128'(m_tvalid), 128'(2'b10));
        rst_n = 1'b0;
        #1;
        chk("mid-reset tvalid", 128'(m_tvalid), 128'(0));
        chk("mid-reset tready", 128'(s_tready), 128'(0));
        chk("mid-reset rd_outstanding", 128'(rd_out), 128'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(1, 0, 0, 1, 2'b11, 2'b00);
        #4;
        chk("post-reset idle tvalid", 128'(m_tvalid), 128'(2'b01));
        chk("post-reset idle tready", 128'(s_tready), 128'(1));
`ifdef CQ_DISPATCH_DROP_EN
        chk("post-reset drop_count", 128'(drop_count), 128'(0));
`endif

        // Randomized traffic against the reference model.
        @(posedge clk); #1;
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        for (int p = 0; p < NP; p++) m_cnt[p] = 0;
        m_in_pkt = 0; m_in_drop = 0; m_cur = 0; m_drops = 0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk); #1;
            drive(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), $urandom_range(0, 1),
                  $urandom_range(0, 1), NP'($urandom), {$urandom_range(0, 5) == 0,
                  $urandom_range(0, 5) == 0});
            #4;
            m_bar    = s_tuser[8:6];
            m_rd     = (s_tuser[5:2] == 4'b0000);
            m_mapped = (int'(m_bar) < NP);
            m_port   = m_mapped ? int'(m_bar) : 0;
            e_tv = '0;
            e_tr = 1'b0;
            if (m_in_drop) begin
                e_tr = 1'b1;
            end else if (m_in_pkt) begin
                e_tv[m_cur] = s_tvalid;
                e_tr        = m_tready[m_cur];
            end else if (DropEn && !m_mapped) begin
                e_tr = 1'b1;
            end else if (!(m_rd && m_cnt[m_port] == MAXO)) begin
                e_tv[m_port] = s_tvalid;
                e_tr         = m_tready[m_port];
            end
            for (int p = 0; p < NP; p++) e_ro[4*p +: 4] = 4'(m_cnt[p]);

            chk("rand tvalid", 128'(m_tvalid), 128'(e_tv));
            chk("rand tready", 128'(s_tready), 128'(e_tr));
            chk("rand rd_outstanding", 128'(rd_out), 128'(e_ro));
            chk("rand tuser", 128'(m_tuser), 128'(s_tuser));
`ifdef CQ_DISPATCH_DROP_EN
            chk("rand drop_count", 128'(drop_count), 128'(m_drops));
`endif

            m_hs = s_tvalid && e_tr;
            for (int p = 0; p < NP; p++) m_inc[p] = 1'b0;
            if (m_hs) begin
                if (m_in_drop) begin
                    if (s_tlast) m_in_drop = 0;
                end else if (m_in_pkt) begin
                    if (s_tlast) m_in_pkt = 0;
                end else if (DropEn && !m_mapped) begin
                    if (m_drops < 65535) m_drops++;
                    if (!s_tlast) m_in_drop = 1;
                end else begin
                    if (m_rd) m_inc[m_port] = 1'b1;
                    if (!s_tlast) begin
                        m_in_pkt = 1;
                        m_cur    = m_port;
                    end
                end
            end
            for (int p = 0; p < NP; p++) begin
                if (m_inc[p] && rd_done[p]) m_cnt[p] = m_cnt[p];
                else if (m_inc[p]) m_cnt[p]++;
                else if (rd_done[p] && m_cnt[p] > 0) m_cnt[p]--;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
